// File: rtl/dm_arbiter_pkg.sv
// Shared access-type codes, FSM states and request bundle
// for the data-memory arbiter.
package dm_arbiter_pkg;

  localparam logic [1:0] dm_word = 2'b00;
  localparam logic [1:0] dm_half = 2'b01;
  localparam logic [1:0] dm_byte = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  typ;
    logic        sext;
  } dm_req_t;

  function automatic logic misaligned(
    input logic [1:0] off,
    input logic [1:0] typ
  );
    return (typ == dm_half && off[0]) ||
           (typ == dm_word && off != 2'b00);
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte/half extract-extend for loads and
// byte/half merge for read-modify-write stores.
module dm_lane
  import dm_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  typ,
  input  logic        sext,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{off, 3'b000} +: 8];
    h      = off[1] ? word[31:16] : word[15:0];
    rdata  = word;
    merged = wdata;
    unique case (1'b1)
      typ == dm_byte: begin
        rdata  = {{24{sext & b[7]}}, b};
        merged = word;
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      typ == dm_half: begin
        rdata  = {{16{sext & h[15]}}, h};
        merged = word;
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port DM;
// sub-word stores run as a two-cycle read-modify-write.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req0_we,
  input  logic        req1_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req1_wdata,
  input  logic [1:0]  req0_type,
  input  logic [1:0]  req1_type,
  input  logic        req0_sext,
  input  logic        req1_sext,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp0_rdata,
  output logic [31:0] rsp1_rdata,
  output logic        rsp0_err,
  output logic        rsp1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_n;
  logic        rr, rr_n;
  logic [31:0] lat_addr, lat_word;
  logic        lat_port;
  dm_req_t     r0, r1, req;
  logic        gnt, acc, err, sub;
  logic [31:0] lane_rdata, lane_merged;
  logic        rv_n, rp_n, re_n;
  logic [31:0] rd_n;

  always_comb begin
    r0 = '{we: req0_we, addr: req0_addr,
           wdata: req0_wdata, typ: req0_type,
           sext: req0_sext};
    r1 = '{we: req1_we, addr: req1_addr,
           wdata: req1_wdata, typ: req1_type,
           sext: req1_sext};
    if (req0_valid && req1_valid)
      gnt = FIXED_PRIO ? 1'b0 : ~rr;
    else
      gnt = req1_valid;
    req = gnt ? r1 : r0;
    acc = reset && state == IDLE &&
          (req0_valid || req1_valid);
    err = misaligned(req.addr[1:0], req.typ) ||
          ((req.addr >> ADDR_W) != 32'd0);
    sub = req.we &&
          (req.typ == dm_half || req.typ == dm_byte);
  end

  dm_lane u_lane (
    .word   (mem_rdata),
    .wdata  (req.wdata),
    .off    (req.addr[1:0]),
    .typ    (req.typ),
    .sext   (req.sext),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

  always_comb begin
    state_n    = state;
    rr_n       = rr;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rv_n       = 1'b0;
    rp_n       = lat_port;
    rd_n       = '0;
    re_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          req0_ready = ~gnt;
          req1_ready = gnt;
          rr_n       = gnt;
          rv_n       = 1'b1;
          rp_n       = gnt;
          if (err) begin
            re_n = 1'b1;
          end else if (!req.we) begin
            mem_addr = req.addr;
            rd_n     = lane_rdata;
          end else if (sub) begin
            mem_addr = req.addr;
            rv_n     = 1'b0;
            state_n  = RMW;
          end else begin
            mem_addr  = req.addr;
            mem_wdata = req.wdata;
            mem_we    = 1'b1;
          end
        end
      end
      RMW: begin
        // reset gates the write so an abandoned RMW never lands
        mem_addr  = lat_addr;
        mem_wdata = lat_word;
        mem_we    = reset;
        rv_n      = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rr         <= 1'b0;
      lat_addr   <= '0;
      lat_word   <= '0;
      lat_port   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_err   <= 1'b0;
    end else begin
      state      <= state_n;
      rr         <= rr_n;
      rsp0_valid <= rv_n & ~rp_n;
      rsp1_valid <= rv_n & rp_n;
      rsp0_rdata <= rp_n ? '0 : rd_n;
      rsp1_rdata <= rp_n ? rd_n : '0;
      rsp0_err   <= re_n & ~rp_n;
      rsp1_err   <= re_n & rp_n;
      if (acc && sub && !err) begin
        lat_addr <= req.addr;
        lat_word <= lane_merged;
        lat_port <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench: random two-port traffic vs a
// word-array reference model, plus directed corner cases.
module tb_dm_arbiter;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;

  typedef struct {
    logic [31:0] d;
    bit          e;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        v[2], w[2], sx[2];
  logic [31:0] a[2], wd[2];
  logic [1:0]  ty[2];
  logic        rdy[2], rv[2], re[2];
  logic [31:0] rd[2];
  logic [31:0] maddr, mwdata, mrdata;
  logic        mwe;

  logic        fv[2];
  logic        frdy[2], frv[2], fre[2];
  logic [31:0] frd[2];
  logic [31:0] fmaddr, fmwdata;
  logic        fmwe;
  logic [31:0] fzero = 32'h0;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  bit          mem_init = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  exp_t        q[2][$];
  int          gseq[$];
  logic [31:0] last_rd[2];
  logic        last_re[2];
  bit          last, busy, pend_port;
  int          pend_idx;
  logic [31:0] pend_word;

  dm_arbiter #(.ADDR_W(12), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req1_valid(v[1]),
    .req0_we(w[0]), .req1_we(w[1]),
    .req0_addr(a[0]), .req1_addr(a[1]),
    .req0_wdata(wd[0]), .req1_wdata(wd[1]),
    .req0_type(ty[0]), .req1_type(ty[1]),
    .req0_sext(sx[0]), .req1_sext(sx[1]),
    .req0_ready(rdy[0]), .req1_ready(rdy[1]),
    .rsp0_valid(rv[0]), .rsp1_valid(rv[1]),
    .rsp0_rdata(rd[0]), .rsp1_rdata(rd[1]),
    .rsp0_err(re[0]), .rsp1_err(re[1]),
    .mem_addr(maddr), .mem_wdata(mwdata),
    .mem_we(mwe), .mem_rdata(mrdata)
  );

  dm_arbiter #(.ADDR_W(12), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(fv[0]), .req1_valid(fv[1]),
    .req0_we(1'b0), .req1_we(1'b0),
    .req0_addr(32'h0), .req1_addr(32'h0),
    .req0_wdata(32'h0), .req1_wdata(32'h0),
    .req0_type(W), .req1_type(W),
    .req0_sext(1'b0), .req1_sext(1'b0),
    .req0_ready(frdy[0]), .req1_ready(frdy[1]),
    .rsp0_valid(frv[0]), .rsp1_valid(frv[1]),
    .rsp0_rdata(frd[0]), .rsp1_rdata(frd[1]),
    .rsp0_err(fre[0]), .rsp1_err(fre[1]),
    .mem_addr(fmaddr), .mem_wdata(fmwdata),
    .mem_we(fmwe), .mem_rdata(fzero)
  );

  function automatic logic [31:0] seed(int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  assign mrdata = mem[maddr[11:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed(i);
    end else if (mwe) begin
      mem[maddr[11:2]] <= mwdata;
    end
  end

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0d",
               n, act, exp, cyc);
    end
  endtask

  function automatic bit is_err(logic [31:0] ad,
                                logic [1:0] t);
    if (t == H && ad[0]) return 1'b1;
    if (t == W && ad[1:0] != 2'b00) return 1'b1;
    return ad >= 32'd4096;
  endfunction

  function automatic logic [31:0] ld_val(
    logic [31:0] wrd, logic [31:0] ad,
    logic [1:0] t, bit s);
    logic [31:0] x;
    x = wrd;
    if (t == B) begin
      x = (wrd >> (8 * ad[1:0])) & 32'hFF;
      if (s && x >= 32'h80) x = x | 32'hFFFFFF00;
    end else if (t == H) begin
      x = (wrd >> (16 * ad[1])) & 32'hFFFF;
      if (s && x >= 32'h8000) x = x | 32'hFFFF0000;
    end
    return x;
  endfunction

  function automatic logic [31:0] merge(
    logic [31:0] wrd, logic [31:0] dat,
    logic [31:0] ad, logic [1:0] t);
    logic [31:0] m;
    int          sh;
    sh = (t == B) ? 8 * ad[1:0] : 16 * ad[1];
    m  = ((t == B) ? 32'hFF : 32'hFFFF) << sh;
    return (wrd & ~m) | ((dat << sh) & m);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
    last = 1'b0;
    busy = 1'b0;
    forever begin
      bit   g[2];
      bit   exp_we;
      int   p;
      exp_t e;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rv[k] === 1'b1) begin
          if (q[k].size() == 0) begin
            chk($sformatf("rsp%0d_unexpected", k), 1, 0);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("rsp%0d_rdata", k), rd[k], e.d);
            chk($sformatf("rsp%0d_err", k),
                {31'b0, re[k]}, {31'b0, e.e});
            chk($sformatf("rsp%0d_cycle", k), cyc, e.t);
            last_rd[k] = rd[k];
            last_re[k] = re[k];
          end
        end
      end
      g[0] = 1'b0;
      g[1] = 1'b0;
      p = 0;
      exp_we = 1'b0;
      if (busy) begin
        if (reset) begin
          ref_mem[pend_idx] = pend_word;
          q[pend_port].push_back('{32'h0, 1'b0, cyc + 1});
          exp_we = 1'b1;
        end
        busy = 1'b0;
      end else if (reset) begin
        if (v[0] && v[1]) p = last ? 0 : 1;
        else p = v[1] ? 1 : 0;
        g[p] = v[0] | v[1];
      end
      if (!reset) last = 1'b0;
      chk("ready0", {31'b0, rdy[0]}, {31'b0, g[0]});
      chk("ready1", {31'b0, rdy[1]}, {31'b0, g[1]});
      if (g[0] || g[1]) begin
        int idx;
        idx  = int'(a[p][11:2]);
        last = p[0];
        gseq.push_back(p);
        if (is_err(a[p], ty[p])) begin
          q[p].push_back('{32'h0, 1'b1, cyc + 1});
        end else if (!w[p]) begin
          q[p].push_back('{ld_val(ref_mem[idx], a[p],
                          ty[p], sx[p]), 1'b0, cyc + 1});
        end else if (ty[p] == W) begin
          ref_mem[idx] = wd[p];
          exp_we = 1'b1;
          q[p].push_back('{32'h0, 1'b0, cyc + 1});
        end else begin
          busy      = 1'b1;
          pend_port = p[0];
          pend_idx  = idx;
          pend_word = merge(ref_mem[idx], wd[p],
                            a[p], ty[p]);
        end
      end
      chk("mem_we", {31'b0, mwe}, {31'b0, exp_we});
    end
  end

  task automatic issue(int p, bit we, logic [31:0] ad,
                       logic [31:0] dat, logic [1:0] t,
                       bit s);
    int n;
    v[p] = 1'b1; w[p] = we; a[p] = ad;
    wd[p] = dat; ty[p] = t; sx[p] = s;
    n = 0;
    @(negedge clk);
    while (!rdy[p] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!rdy[p]) chk($sformatf("grant%0d_timeout", p), 0, 1);
    @(posedge clk);
    #1;
    v[p] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_port(int p, int n);
    logic [1:0]  t;
    logic [31:0] ad;
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      t  = 2'($urandom_range(0, 2));
      ad = $urandom_range(0, 63) * 4;
      if (t == B) ad += $urandom_range(0, 3);
      if (t == H) ad += $urandom_range(0, 1) * 2;
      if ($urandom_range(0, 9) == 0) ad += $urandom_range(1, 3);
      if ($urandom_range(0, 11) == 0) ad |= 32'h1000;
      issue(p, $urandom_range(0, 1) == 1, ad,
            $urandom, t, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    int          n;
    int          errs;
    for (int k = 0; k < 2; k++) begin
      v[k] = 0; w[k] = 0; a[k] = 0; wd[k] = 0;
      ty[k] = W; sx[k] = 0; fv[k] = 0;
    end
    @(posedge clk);
    #1;
    mem_init = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_rsp0", {31'b0, rv[0]}, 0);
    chk("rst_rsp1", {31'b0, rv[1]}, 0);
    chk("rst_rdata0", rd[0], 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);

    issue(0, 1, 32'h10, 32'h12345678, W, 0);
    issue(0, 0, 32'h10, 32'h0, W, 0);
    idle(2);
    chk("word_load", last_rd[0], 32'h12345678);
    chk("word_load_err", {31'b0, last_re[0]}, 0);
    chk("word_mem", mem[4], 32'h12345678);

    issue(0, 1, 32'h20, 32'hAABBCCDD, W, 0);
    issue(0, 1, 32'h22, 32'h00000011, B, 0);
    idle(2);
    chk("byte_rmw_mem", mem[8], 32'hAA11CCDD);
    issue(0, 1, 32'h20, 32'hAABBCCDD, W, 0);
    issue(0, 0, 32'h23, 32'h0, B, 1);
    idle(2);
    chk("lb_23", last_rd[0], 32'hFFFFFFAA);
    issue(0, 0, 32'h23, 32'h0, B, 0);
    idle(2);
    chk("lbu_23", last_rd[0], 32'h000000AA);
    issue(0, 0, 32'h22, 32'h0, H, 1);
    idle(2);
    chk("lh_22", last_rd[0], 32'hFFFFAABB);

    issue(0, 0, 32'h21, 32'h0, H, 0);
    idle(2);
    chk("mis_err", {31'b0, last_re[0]}, 1);
    chk("mis_rdata", last_rd[0], 0);
    issue(0, 1, 32'h1000, 32'hDEADBEEF, W, 0);
    idle(2);
    chk("oor_err", {31'b0, last_re[0]}, 1);
    chk("oor_mem", mem[0], seed(0));

    gseq.delete();
    fork
      for (int i = 0; i < 3; i++) issue(0, 0, 32'h10, 0, W, 0);
      for (int i = 0; i < 3; i++) issue(1, 0, 32'h20, 0, W, 0);
    join
    chk("alt_count", gseq.size(), 6);
    for (int i = 1; i < gseq.size(); i++)
      chk("alt_order", gseq[i], 1 - gseq[i-1]);

    saved = mem[12];
    issue(0, 1, 32'h31, 32'h77, B, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    chk("rst_rmw_mem", mem[12], saved);
    issue(0, 0, 32'h30, 32'h0, W, 0);
    idle(2);
    chk("rst_rmw_load", last_rd[0], saved);

    fork
      rand_port(0, 150);
      rand_port(1, 150);
    join
    idle(3);

    fv[0] = 1'b1;
    fv[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("fp_rdy0", {31'b0, frdy[0]}, 1);
      chk("fp_rdy1", {31'b0, frdy[1]}, 0);
      chk("fp_maddr", fmaddr, 0);
      chk("fp_we", {31'b0, fmwe}, 0);
      if (i > 0) begin
        chk("fp_rsp0", {31'b0, frv[0]}, 1);
        chk("fp_rsp1", {31'b0, frv[1]}, 0);
        chk("fp_rd0", frd[0] | frd[1] | fmwdata, 0);
        chk("fp_err", {30'b0, fre[0], fre[1]}, 0);
      end
    end
    fv[0] = 1'b0;
    fv[1] = 1'b0;

    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || busy)
           && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q[0].size() + q[1].size(), 0);
    errs = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== ref_mem[i]) errs++;
    chk("mem_image", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
